// File: rtl/seq_detector_prog_if.sv
// Serial-stream, configuration and status bundle for the programmable
// pattern detector. The DUT side uses the slave modport.
interface seq_detector_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               din;
  logic               din_valid;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               detect;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;

  modport master (
    output din, din_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  detect, match_cnt, busy
  );

  modport slave (
    input  din, din_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output detect, match_cnt, busy
  );
endinterface

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with a registered Moore match
// flag, selectable overlap mode and a saturating match counter.
module seq_detector_prog #(
  parameter int               MAX_LEN     = 8,
  parameter int               CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1000),
  parameter int               DEF_LEN     = 4,
  parameter logic             DEF_OVERLAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  seq_detector_prog_if.slave bus
);

  localparam int                 LEN_W     = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   DEF_LEN_L = LEN_W'(DEF_LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] hist_r;
  logic [LEN_W-1:0]   fill_r;
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
  logic               detect_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;

  logic [MAX_LEN-1:0] hist_shift_s;
  logic [LEN_W-1:0]   fill_inc_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               match_s;
  logic [LEN_W-1:0]   len_clamp_s;
  logic [MAX_LEN-1:0] hist_nx_s;
  logic [LEN_W-1:0]   fill_nx_s;
  logic [CNT_W-1:0]   cnt_nx_s;

  // Candidate post-shift history and saturating fill count.
  always_comb begin
    hist_shift_s = {hist_r[MAX_LEN-2:0], bus.din};
    if (fill_r >= MAX_LEN_L) begin
      fill_inc_s = MAX_LEN_L;
    end else begin
      fill_inc_s = fill_r + LEN_W'(1);
    end
  end

  // Compare mask covering the low len_r history bits.
  always_comb begin
    mask_s = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len_r) begin
        mask_s[i] = 1'b1;
      end else begin
        mask_s[i] = 1'b0;
      end
    end
  end

  // Match is judged on the state this sample would produce.
  always_comb begin
    match_s = 1'b0;
    if (bus.din_valid && !bus.cfg_we && (len_r != {LEN_W{1'b0}}) &&
        (fill_inc_s >= len_r) &&
        (((hist_shift_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}})) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
  end

  // Oversized lengths fall back to the full history width.
  always_comb begin
    if (bus.cfg_len > MAX_LEN_L) begin
      len_clamp_s = MAX_LEN_L;
    end else begin
      len_clamp_s = bus.cfg_len;
    end
  end

  // History/fill update: configuration flushes, samples shift.
  always_comb begin
    hist_nx_s = hist_r;
    fill_nx_s = fill_r;
    if (bus.cfg_we) begin
      hist_nx_s = {MAX_LEN{1'b0}};
      fill_nx_s = {LEN_W{1'b0}};
    end else if (bus.din_valid) begin
      hist_nx_s = hist_shift_s;
      // Without overlap the next match must be built from fresh bits only.
      if (match_s && !ovl_r) begin
        fill_nx_s = {LEN_W{1'b0}};
      end else begin
        fill_nx_s = fill_inc_s;
      end
    end else begin
      hist_nx_s = hist_r;
      fill_nx_s = fill_r;
    end
  end

  // Match counter: clear wins over a coincident increment.
  always_comb begin
    cnt_nx_s = cnt_r;
    if (bus.cnt_clr) begin
      cnt_nx_s = {CNT_W{1'b0}};
    end else if (match_s && (cnt_r != CNT_MAX)) begin
      cnt_nx_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nx_s = cnt_r;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_r   <= {MAX_LEN{1'b0}};
      fill_r   <= {LEN_W{1'b0}};
      detect_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
    end else begin
      hist_r   <= hist_nx_s;
      fill_r   <= fill_nx_s;
      detect_r <= match_s;
      cnt_r    <= cnt_nx_s;
      busy_r   <= (fill_nx_s != {LEN_W{1'b0}});
    end
  end

  // Configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r <= DEF_PATTERN;
      len_r <= DEF_LEN_L;
      ovl_r <= DEF_OVERLAP;
    end else if (bus.cfg_we) begin
      pat_r <= bus.cfg_pattern;
      len_r <= len_clamp_s;
      ovl_r <= bus.cfg_overlap;
    end else begin
      pat_r <= pat_r;
      len_r <= len_r;
      ovl_r <= ovl_r;
    end
  end

  assign bus.detect    = detect_r;
  assign bus.match_cnt = cnt_r;
  assign bus.busy      = busy_r;

endmodule
